// File: rtl/pipeline_foreground_config.sv
// Frame-synchronous config sequencer for the foreground scale stage.
// Shadows scale/offset writes and applies them only on frame_start.
//
// Ports:
//   clk, rst              pixel clock, sync active-high reset
//   frame_start           first-active-pixel pulse
//   cmd_valid/ready       write handshake; cmd_addr/cmd_data select/data
//   ctrl_foreground_scale active scale mode
//   fg_offset_x/y         active offsets
//   busy, commit_done     commit in flight / targets reached pulse
module pipeline_foreground_config #(
  parameter int RESOLUTION_X = 800,
  parameter int RESOLUTION_Y = 600,
  parameter int PRECISION    = 10,
  parameter int STEP         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_addr,
  input  logic [15:0]          cmd_data,
  output logic [1:0]           ctrl_foreground_scale,
  output logic [PRECISION-1:0] fg_offset_x,
  output logic [PRECISION-1:0] fg_offset_y,
  output logic                 busy,
  output logic                 commit_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PENDING,
    S_ANIMATE
  } state_e;

  localparam logic [PRECISION-1:0] MAX_X =
    PRECISION'(RESOLUTION_X - 1);
  localparam logic [PRECISION-1:0] MAX_Y =
    PRECISION'(RESOLUTION_Y - 1);
  localparam logic [PRECISION-1:0] STEP_U =
    PRECISION'(STEP);
  localparam logic signed [PRECISION:0] STEP_S =
    (PRECISION+1)'(STEP);

  state_e               state_q, state_d;
  logic [1:0]           shadow_scale_q, shadow_scale_d;
  logic [PRECISION-1:0] target_x_q, target_x_d;
  logic [PRECISION-1:0] target_y_q, target_y_d;
  logic                 animate_q, animate_d;
  logic [1:0]           scale_q, scale_d;
  logic [PRECISION-1:0] off_x_q, off_x_d;
  logic [PRECISION-1:0] off_y_q, off_y_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic [PRECISION-1:0] wr_val;
  logic [PRECISION-1:0] step_x, step_y;
  logic                 at_target;
  logic                 unused_data;

  assign unused_data = ^cmd_data[15:PRECISION];

  // Move cur toward tgt by at most STEP. The difference is taken
  // one bit wider and signed so large gaps never wrap.
  function automatic logic [PRECISION-1:0] step_to(
    input logic [PRECISION-1:0] cur,
    input logic [PRECISION-1:0] tgt
  );
    logic signed [PRECISION:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S)
      step_to = cur + STEP_U;
    else if (diff < -STEP_S)
      step_to = cur - STEP_U;
    else
      step_to = tgt;
  endfunction

  assign accept = cmd_valid && ready_q;
  assign wr_val = cmd_data[PRECISION-1:0];
  assign step_x = step_to(off_x_q, target_x_q);
  assign step_y = step_to(off_y_q, target_y_q);
  assign at_target = (step_x == target_x_q) &&
                     (step_y == target_y_q);

  always_comb begin
    state_d        = state_q;
    shadow_scale_d = shadow_scale_q;
    target_x_d     = target_x_q;
    target_y_d     = target_y_q;
    animate_d      = animate_q;
    scale_d        = scale_q;
    off_x_d        = off_x_q;
    off_y_d        = off_y_q;
    ready_d        = ready_q;
    busy_d         = busy_q;
    done_d         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // frame_start is ignored here, including one that
        // coincides with the commit write.
        if (accept) begin
          unique case (cmd_addr)
            2'd0: shadow_scale_d = cmd_data[1:0];
            2'd1: target_x_d =
                    (wr_val > MAX_X) ? MAX_X : wr_val;
            2'd2: target_y_d =
                    (wr_val > MAX_Y) ? MAX_Y : wr_val;
            2'd3: begin
              animate_d = cmd_data[0];
              state_d   = S_PENDING;
              ready_d   = 1'b0;
              busy_d    = 1'b1;
            end
            default: ;
          endcase
        end
      end

      S_PENDING: begin
        if (frame_start) begin
          scale_d = shadow_scale_q;
          if (!animate_q) begin
            off_x_d = target_x_q;
            off_y_d = target_y_q;
          end else begin
            off_x_d = step_x;
            off_y_d = step_y;
          end
          if (!animate_q || at_target) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_ANIMATE;
          end
        end
      end

      S_ANIMATE: begin
        if (frame_start) begin
          off_x_d = step_x;
          off_y_d = step_y;
          if (at_target) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      shadow_scale_q <= 2'b00;
      target_x_q     <= '0;
      target_y_q     <= '0;
      animate_q      <= 1'b0;
      scale_q        <= 2'b00;
      off_x_q        <= '0;
      off_y_q        <= '0;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_scale_q <= shadow_scale_d;
      target_x_q     <= target_x_d;
      target_y_q     <= target_y_d;
      animate_q      <= animate_d;
      scale_q        <= scale_d;
      off_x_q        <= off_x_d;
      off_y_q        <= off_y_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign cmd_ready             = ready_q;
  assign busy                  = busy_q;
  assign commit_done           = done_q;
  assign ctrl_foreground_scale = scale_q;
  assign fg_offset_x           = off_x_q;
  assign fg_offset_y           = off_y_q;

endmodule

// File: doc/pipeline_foreground_config.md
# pipeline_foreground_config

Frame-synchronous configuration sequencer for the foreground scale stage of the video pipeline. It accepts register writes from the control interface into shadow registers. It commits the foreground scale mode and X/Y offset to the scale stage only at a frame boundary, so settings never change mid-frame. Optionally it slides the offsets toward their targets in fixed steps, one step per frame. It sits between the command decoder and the foreground scale stage, driving that stage's `ctrl_foreground_scale`, `fg_offset_x` and `fg_offset_y` inputs.

## Interface
- `RESOLUTION_X`, 800, active pixels per line; offset X clamp bound
- `RESOLUTION_Y`, 600, active lines per frame; offset Y clamp bound
- `PRECISION`, 10, coordinate/offset width
- `STEP`, 8, maximum offset change per frame while animating
- `clk`  in  1  pixel clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `frame_start`  in  1  one-cycle pulse at the first active pixel of a frame
- `cmd_valid`  in  1  write request
- `cmd_ready`  out  1  block can accept a write
- `cmd_addr`  in  2  register select: 0 scale, 1 offset X, 2 offset Y, 3 commit
- `cmd_data`  in  16  write data
- `ctrl_foreground_scale`  out  2  active scale mode (11 full, 10 half, 01 quarter, 00 off)
- `fg_offset_x`  out  PRECISION  active foreground X offset
- `fg_offset_y`  out  PRECISION  active foreground Y offset
- `busy`  out  1  commit pending or animation in progress
- `commit_done`  out  1  one-cycle pulse when active settings reach their targets

## Operation
- A write is accepted on a rising edge with `cmd_valid && cmd_ready`. Writes with `cmd_ready` low are ignored; the requester holds `cmd_valid`.
- Addr 0: `shadow_scale <= cmd_data[1:0]`.
- Addr 1: `target_x <= min(cmd_data[PRECISION-1:0], RESOLUTION_X-1)`.
- Addr 2: `target_y <= min(cmd_data[PRECISION-1:0], RESOLUTION_Y-1)`. Clamping applies at write time.
- Addr 3: commit request. `animate <= cmd_data[0]`, then enter PENDING. `cmd_data[15:1]` is ignored.
- State IDLE:
  - `cmd_ready`=1, `busy`=0.
  - A commit write moves the block to PENDING.
- State PENDING:
  - `cmd_ready`=0, `busy`=1.
  - On `frame_start`, `ctrl_foreground_scale <= shadow_scale`.
  - If `animate`=0: offsets load their targets, the block returns to IDLE and pulses `commit_done`.
  - If `animate`=1: each offset takes its first step (rule below), then the block goes to ANIMATE. If both offsets reach their targets on that step, it goes directly to IDLE with `commit_done`.
- State ANIMATE:
  - `cmd_ready`=0, `busy`=1.
  - On each `frame_start`, each offset moves toward its target by `min(STEP, |target-offset|)`.
  - The difference is computed at PRECISION+1 bits signed, so there is no wrap-around.
  - When both offsets equal their targets after the update, go to IDLE and pulse `commit_done` in the same cycle the final values appear.
- A commit whose targets already equal the active values still waits for `frame_start` and still pulses `commit_done`.
- Shadow and target registers hold their values across commits. Re-committing without new writes reapplies the same values.

## Timing
- Reset values:
  - `ctrl_foreground_scale`=00, `fg_offset_x`=0, `fg_offset_y`=0.
  - `cmd_ready`=1, `busy`=0, `commit_done`=0.
  - Shadow scale 00, targets 0, `animate`=0, state IDLE.
- All outputs are registered.
- A write accepted at edge N updates its shadow/target register at edge N.
- A commit accepted at edge N gives state PENDING, `cmd_ready`=0 and `busy`=1 after edge N.
- A `frame_start` that is high in the same cycle a commit is accepted is not used. The block waits for the next one.
- `frame_start` sampled high at edge M in PENDING or ANIMATE: new active values and any `commit_done` are visible after edge M (latency 1 cycle).
- After `commit_done`, `cmd_ready`=1 and `busy`=0 from the same edge.
- `frame_start` while in IDLE has no effect.
- `rst` asserted in any state, including mid-animation: on the next edge all registers take their reset values and any pending commit is discarded.

## Test plan
- Reset, write scale=10, offset X=100, offset Y=50, then commit with data=0; pulse `frame_start` 20 cycles later. Required: outputs stay 00/0/0 until that edge, then become 10/100/50 with a single `commit_done` pulse; `cmd_ready` is 0 between the commit and that edge.
- Write offset X=1000. Required: `target_x` clamps to 799; after a commit and `frame_start`, `fg_offset_x`=799.
- Start from X=0, write target X=20 and Y=0, commit with animate=1. Required: `fg_offset_x` is 8, 16, 20 on three successive `frame_start` pulses, and `commit_done` is asserted only with the value 20.
- Animate downward from X=20 to target 3 with STEP=8. Required: X goes 12, 4, 3 with no underflow or wrap; `busy` stays high until the 3 appears.
- Commit accepted in the same cycle as `frame_start`. Required: that pulse is ignored and the apply happens on the next `frame_start`.
- Assert `rst` for 1 cycle mid-animation at X=16. Required: all outputs return to reset values with `cmd_ready`=1, and later `frame_start` pulses change nothing.
